cnn_conv_scheduler: RTL and testbench

Frame-level controller for the 5x5 convolution MAC datapath. It walks a feature map held in an external single-port memory and, for every valid-padding output position, streams the 25 window taps (1.7.24 fixed-point data plus tap index) into the datapath. It then collects each result and writes it into a result memory. It sits between the feature-map buffer and the convolution datapath, replacing ad-hoc testbench sequencing of `cnn_en`/`input_data`/`input_addr`.

---
 rtl/cnn_pkg.sv | 21 ++
 rtl/cnn_win_addr_gen.sv | 81 ++++++++
 rtl/cnn_conv_scheduler.sv | 150 +++++++++++++++
 tb/tb_cnn_conv_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and constants for the 5x5 convolution scheduler slice.
// Data is signed 1.7.24 fixed point; the scheduler never does arithmetic on it.
package cnn_pkg;

    localparam int DATA_W    = 32;
    localparam int FRAC_BITS = 24;
    localparam int TAP_W     = 5;

    // 1.0 in 1.7.24
    localparam logic [DATA_W-1:0] ONE = DATA_W'(1) << FRAC_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_TAP,
        S_WAIT,
        S_WR,
        S_DONE
    } sched_state_e;

endpackage

// File: rtl/cnn_win_addr_gen.sv
// Window address generator: nested kx/ky/ox/oy counters plus flat tap index.
// Ports: i_clr zeroes all counters, i_tap_adv steps to the next tap,
// i_pos_adv moves to the next output position (tap back to 0).
// o_rd_addr = (oy+ky)*IMG_W+ox+kx, o_res_addr = oy*OUT_W+ox,
// o_tap = current tap, o_last_tap / o_last_pos flag the final tap / position.
module cnn_win_addr_gen
    import cnn_pkg::*;
#(
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int K      = 5,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_tap_adv,
    input  logic              i_pos_adv,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic [ADDR_W-1:0] o_res_addr,
    output logic [TAP_W-1:0]  o_tap,
    output logic              o_last_tap,
    output logic              o_last_pos
);

    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;

    localparam logic [ADDR_W-1:0] KM1  = ADDR_W'(K - 1);
    localparam logic [ADDR_W-1:0] OXM  = ADDR_W'(OUT_W - 1);
    localparam logic [ADDR_W-1:0] OYM  = ADDR_W'(OUT_H - 1);
    localparam logic [ADDR_W-1:0] IW   = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] OW   = ADDR_W'(OUT_W);
    localparam logic [TAP_W-1:0]  TLST = TAP_W'(K * K - 1);

    logic [ADDR_W-1:0] r_kx, r_ky, r_ox, r_oy;
    logic [TAP_W-1:0]  r_t;
    logic [ADDR_W-1:0] w_row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kx <= '0;
            r_ky <= '0;
            r_ox <= '0;
            r_oy <= '0;
            r_t  <= '0;
        end else if (i_clr) begin
            r_kx <= '0;
            r_ky <= '0;
            r_ox <= '0;
            r_oy <= '0;
            r_t  <= '0;
        end else if (i_pos_adv) begin
            r_kx <= '0;
            r_ky <= '0;
            r_t  <= '0;
            if (r_ox == OXM) begin
                r_ox <= '0;
                r_oy <= r_oy + 1'b1;
            end else begin
                r_ox <= r_ox + 1'b1;
            end
        end else if (i_tap_adv) begin
            r_t <= r_t + 1'b1;
            if (r_kx == KM1) begin
                r_kx <= '0;
                r_ky <= r_ky + 1'b1;
            end else begin
                r_kx <= r_kx + 1'b1;
            end
        end
    end

    assign w_row      = r_oy + r_ky;
    assign o_rd_addr  = w_row * IW + r_ox + r_kx;
    assign o_res_addr = r_oy * OW + r_ox;
    assign o_tap      = r_t;
    assign o_last_tap = (r_t == TLST);
    assign o_last_pos = (r_ox == OXM) && (r_oy == OYM);

endmodule

// File: rtl/cnn_conv_scheduler.sv
// Frame controller: walks every valid 5x5 window, streams taps to the MAC
// datapath, collects each result and writes it to the result memory.
// Ports: i_start/o_busy/o_done frame control; o_fm_rd_* / i_fm_rd_data
// feature-map read (1-cycle latency); o_cnn_* / i_cnn_* datapath tap
// handshake and result; o_res_wr_* result write; o_timeout_err sticky error.
module cnn_conv_scheduler
    import cnn_pkg::*;
#(
    parameter int IMG_W   = 16,
    parameter int IMG_H   = 16,
    parameter int K       = 5,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_fm_rd_en,
    output logic [ADDR_W-1:0] o_fm_rd_addr,
    input  logic [DATA_W-1:0] i_fm_rd_data,
    output logic              o_cnn_start,
    output logic              o_cnn_in_valid,
    input  logic              i_cnn_in_ready,
    output logic [DATA_W-1:0] o_cnn_data,
    output logic [TAP_W-1:0]  o_cnn_tap,
    input  logic              i_cnn_out_valid,
    input  logic [DATA_W-1:0] i_cnn_result,
    output logic              o_res_wr_en,
    output logic [ADDR_W-1:0] o_res_wr_addr,
    output logic [DATA_W-1:0] o_res_wr_data,
    output logic              o_timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    sched_state_e      r_state, w_next;
    logic              r_tap_first;
    logic [DATA_W-1:0] r_cnn_data;
    logic [DATA_W-1:0] r_result;
    logic [CNT_W-1:0]  r_wait;
    logic              r_timeout_err;

    logic              w_clr, w_accept, w_got, w_expire;
    logic [ADDR_W-1:0] w_rd_addr, w_res_addr;
    logic [TAP_W-1:0]  w_tap;
    logic              w_last_tap, w_last_pos;

    assign w_clr    = (r_state == S_IDLE) && i_start;
    assign w_accept = (r_state == S_TAP) && i_cnn_in_ready;
    assign w_got    = (r_state == S_WAIT) && i_cnn_out_valid;
    // A result arriving on the last allowed cycle beats the timeout.
    assign w_expire = (r_state == S_WAIT) && !i_cnn_out_valid
                   && (r_wait == CNT_LAST);

    cnn_win_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .K      (K),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_clr),
        .i_tap_adv  (w_accept && !w_last_tap),
        .i_pos_adv  ((r_state == S_WR) && !w_last_pos),
        .o_rd_addr  (w_rd_addr),
        .o_res_addr (w_res_addr),
        .o_tap      (w_tap),
        .o_last_tap (w_last_tap),
        .o_last_pos (w_last_pos)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (i_start) w_next = S_RD;
            S_RD:   w_next = S_TAP;
            S_TAP:  if (i_cnn_in_ready)
                        w_next = w_last_tap ? S_WAIT : S_RD;
            S_WAIT: if (w_got || w_expire) w_next = S_WR;
            S_WR:   w_next = w_last_pos ? S_DONE : S_RD;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Read data is only valid in the first TAP cycle; hold it for stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tap_first   <= 1'b0;
            r_cnn_data    <= '0;
            r_result      <= '0;
            r_wait        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_tap_first <= (r_state == S_RD);
            if (r_tap_first) r_cnn_data <= i_fm_rd_data;
            if (r_state == S_WAIT) r_wait <= r_wait + 1'b1;
            else                   r_wait <= '0;
            if (w_got)         r_result <= i_cnn_result;
            else if (w_expire) r_result <= '0;
            if (w_clr)         r_timeout_err <= 1'b0;
            else if (w_expire) r_timeout_err <= 1'b1;
        end
    end

    always_comb begin
        o_busy         = (r_state != S_IDLE);
        o_done         = 1'b0;
        o_fm_rd_en     = 1'b0;
        o_fm_rd_addr   = '0;
        o_cnn_start    = 1'b0;
        o_cnn_in_valid = 1'b0;
        o_cnn_data     = '0;
        o_cnn_tap      = '0;
        o_res_wr_en    = 1'b0;
        o_res_wr_addr  = '0;
        o_res_wr_data  = '0;
        unique case (r_state)
            S_RD: begin
                o_fm_rd_en   = 1'b1;
                o_fm_rd_addr = w_rd_addr;
                o_cnn_start  = (w_tap == '0);
            end
            S_TAP: begin
                o_cnn_in_valid = 1'b1;
                o_cnn_data     = r_tap_first ? i_fm_rd_data : r_cnn_data;
                o_cnn_tap      = w_tap;
            end
            S_WR: begin
                o_res_wr_en   = 1'b1;
                o_res_wr_addr = w_res_addr;
                o_res_wr_data = r_result;
            end
            S_DONE: o_done = 1'b1;
            default: ;
        endcase
    end

    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_cnn_conv_scheduler.sv
// Randomized self-checking bench for cnn_conv_scheduler (16x16, K=5).
// A behavioural datapath/memory model and a window-level reference check it.
module tb_cnn_conv_scheduler;

    localparam int IMG_W   = 16;
    localparam int IMG_H   = 16;
    localparam int K       = 5;
    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 255;
    localparam int OUT_W   = IMG_W - K + 1;
    localparam int OUT_H   = IMG_H - K + 1;
    localparam int NPOS    = OUT_W * OUT_H;

    logic              clk, rst_n, start;
    logic              busy, done, fm_rd_en, cnn_start, cnn_in_valid;
    logic [ADDR_W-1:0] fm_rd_addr, res_wr_addr;
    logic [31:0]       fm_rd_data, cnn_data, cnn_result, res_wr_data;
    logic [4:0]        cnn_tap;
    logic              cnn_in_ready, cnn_out_valid, res_wr_en, timeout_err;
    logic [91:0]       outs;

    logic [31:0] mem [256];

    int n_tests, n_fail, cyc;
    int win_idx, tap_idx, done_cnt, cnt, lat, stall_pct;
    int first_rd_cyc, last_wr_cyc;
    bit mon_on, silent, noise, rand_lat, waiting, found;
    logic [31:0] acc_sum, pd;
    logic [4:0]  pt;
    logic        pv, pr;

    cnn_conv_scheduler #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K),
        .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_start         (start),
        .o_busy          (busy),
        .o_done          (done),
        .o_fm_rd_en      (fm_rd_en),
        .o_fm_rd_addr    (fm_rd_addr),
        .i_fm_rd_data    (fm_rd_data),
        .o_cnn_start     (cnn_start),
        .o_cnn_in_valid  (cnn_in_valid),
        .i_cnn_in_ready  (cnn_in_ready),
        .o_cnn_data      (cnn_data),
        .o_cnn_tap       (cnn_tap),
        .i_cnn_out_valid (cnn_out_valid),
        .i_cnn_result    (cnn_result),
        .o_res_wr_en     (res_wr_en),
        .o_res_wr_addr   (res_wr_addr),
        .o_res_wr_data   (res_wr_data),
        .o_timeout_err   (timeout_err)
    );

    assign outs = {busy, done, fm_rd_en, fm_rd_addr, cnn_start,
                   cnn_in_valid, cnn_data, cnn_tap, res_wr_en,
                   res_wr_addr, res_wr_data, timeout_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial fm_rd_data = '0;
    always @(posedge clk) if (fm_rd_en) fm_rd_data <= mem[fm_rd_addr];

    task automatic chk(input string tag, input logic [95:0] got,
                       input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_addr(input int w, input int t);
        int ox, oy;
        ox = w % OUT_W;
        oy = w / OUT_W;
        return (oy + t / K) * IMG_W + ox + t % K;
    endfunction

    function automatic logic [31:0] ref_sum(input int w);
        logic [31:0] s;
        s = '0;
        for (int t = 0; t < K * K; t++) s += mem[exp_addr(w, t)];
        return s;
    endfunction

    task automatic mon_loop();
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_on) begin
                if (fm_rd_en) begin
                    chk("rd_addr", fm_rd_addr, exp_addr(win_idx, tap_idx));
                    chk("cnn_start", cnn_start, tap_idx == 0);
                    if (win_idx == 0 && tap_idx == 0) first_rd_cyc = cyc;
                end
                if (cnn_in_valid) begin
                    chk("rd_en_in_tap", fm_rd_en, 0);
                    chk("tap_idx", cnn_tap, tap_idx);
                    chk("tap_data", cnn_data, mem[exp_addr(win_idx, tap_idx)]);
                    if (pv && !pr) begin
                        chk("stall_data", cnn_data, pd);
                        chk("stall_tap", cnn_tap, pt);
                    end
                end
                if (res_wr_en) begin
                    chk("wr_addr", res_wr_addr, win_idx);
                    chk("wr_data", res_wr_data, silent ? 0 : ref_sum(win_idx));
                    chk("wr_terr", timeout_err, silent);
                    if (stall_pct == 0 && !rand_lat) begin
                        if (win_idx == 0)
                            chk("win0_len", cyc - first_rd_cyc, 2 * K * K + lat);
                        else
                            chk("win_period", cyc - last_wr_cyc,
                                2 * K * K + lat + 1);
                    end
                    last_wr_cyc = cyc;
                    win_idx++;
                    tap_idx = 0;
                    waiting = 0;
                end
                if (done) begin
                    done_cnt++;
                    chk("done_after_wr", cyc - last_wr_cyc, 1);
                    chk("busy_at_done", busy, 1);
                end
                if (cnn_start) acc_sum = '0;
            end
            cnn_out_valid = 1'b0;
            cnn_result    = $urandom;
            if (mon_on && waiting && !silent) begin
                cnt--;
                if (cnt == 0) begin
                    cnn_out_valid = 1'b1;
                    cnn_result    = acc_sum;
                end
            end else if (mon_on && noise && !waiting) begin
                cnn_out_valid = ($urandom_range(7) == 0);
            end
            cnn_in_ready = (stall_pct == 0) ? 1'b1
                         : ($urandom_range(99) >= stall_pct);
            if (mon_on && cnn_in_valid && cnn_in_ready) begin
                acc_sum += cnn_data;
                tap_idx++;
                if (tap_idx == K * K) begin
                    waiting = 1;
                    cnt = rand_lat ? int'($urandom_range(8, 1)) : lat;
                end
            end
            pv = cnn_in_valid;
            pr = cnn_in_ready;
            pd = cnn_data;
            pt = cnn_tap;
        end
    endtask

    task automatic start_frame();
        win_idx  = 0;
        tap_idx  = 0;
        waiting  = 0;
        done_cnt = 0;
        acc_sum  = '0;
        pv       = 1'b0;
        mon_on   = 1;
        start    = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        chk("busy_c1", busy, 1);
        chk("rd_c1", fm_rd_en, 1);
    endtask

    task automatic wait_done(input int budget, input bit poke);
        for (int i = 0; i < budget && done_cnt == 0; i++) begin
            start = poke && (i == 600);
            @(negedge clk);
            #1;
        end
        start = 1'b0;
        chk("done_seen", done_cnt, 1);
        @(negedge clk);
        #1;
        chk("busy_end", busy, 0);
        chk("wr_count", win_idx, NPOS);
        chk("done_once", done_cnt, 1);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        rst_n = 1'b0; start = 1'b0;
        cnn_in_ready = 1'b0; cnn_out_valid = 1'b0; cnn_result = '0;
        mon_on = 0; stall_pct = 0; silent = 0; noise = 0;
        rand_lat = 0; lat = 4; waiting = 0;
        pv = 1'b0; pr = 1'b0; pd = '0; pt = '0;
        first_rd_cyc = 0; last_wr_cyc = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'(i) << 16;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_outs", outs, 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("idle_outs", outs, 0);
        fork
            mon_loop();
        join_none

        // ramp data, ready high, fixed latency, stray out_valid, start poke
        noise = 1; lat = 4;
        start_frame();
        wait_done(20000, 1);

        // silent datapath: every window times out
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        noise = 0; silent = 1; lat = TIMEOUT;
        start_frame();
        wait_done(50000, 0);
        chk("terr_sticky", timeout_err, 1);

        // result exactly on the timeout cycle, then reset mid-window
        silent = 0; lat = TIMEOUT;
        chk("terr_pre", timeout_err, 1);
        start_frame();
        chk("terr_clr", timeout_err, 0);
        found = 0;
        for (int i = 0; i < 5000 && !found; i++) begin
            @(negedge clk);
            #1;
            found = (win_idx == 3) && cnn_in_valid && (cnn_tap == 10);
        end
        chk("tap10_reached", found, 1);
        mon_on = 0;
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", outs, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_outs", outs, 0);

        // full frame from (0,0) with random ready stalls and latencies
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        stall_pct = 30; rand_lat = 1;
        start_frame();
        wait_done(40000, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
